bk_bus_initiator: RTL and testbench

- Bus master for the BK CPU-side bus. It lets a non-CPU agent, such as the host/OSD file loader or the debug monitor, run single read and write transactions against memory and I/O responders like the video register block at 177662/177664.
- It accepts one request at a time on a valid/ready port and converts it into a sync/stb/ack bus cycle. It waits for an arbiter grant before driving the bus.
- It returns the read data, or a timeout error when no responder acknowledges.

---
 rtl/bk_bus_pkg.sv | 59 +++++
 rtl/bk_bus_initiator_if.sv | 41 ++++
 rtl/bk_bus_initiator.sv | 160 ++++++++++++++++
 tb/tb_bk_bus_initiator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_bus_pkg.sv
// bk_bus_pkg -- shared definitions for the BK CPU-side bus initiator.
//   bus_state_t      : initiator FSM states
//   WTBT_*           : byte-enable encodings {hi, lo} driven on bus_wtbt
//   DEFAULT_TIMEOUT  : default strobe timeout in clk_sys cycles
//   byte_replicate   : places a write byte on both lanes
//   byte_extract     : selects the read lane and zero-extends it
//   wtbt_encode      : byte enables for a given access type
package bk_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_STROBE,
        ST_RELEASE
    } bus_state_t;

    localparam logic [1:0] WTBT_NONE = 2'b00;
    localparam logic [1:0] WTBT_LO   = 2'b01;
    localparam logic [1:0] WTBT_HI   = 2'b10;
    localparam logic [1:0] WTBT_WORD = 2'b11;

    localparam int DEFAULT_TIMEOUT = 64;

    // Responders pick the lane they need, so a byte write drives the
    // byte on both halves of the data bus.
    function automatic logic [15:0] byte_replicate(input logic [15:0] data,
                                                   input logic        is_byte);
        return is_byte ? {data[7:0], data[7:0]} : data;
    endfunction

    // Odd byte addresses live in the upper lane.
    function automatic logic [15:0] byte_extract(input logic [15:0] din,
                                                 input logic        is_byte,
                                                 input logic        addr_lsb);
        logic [15:0] result;
        result = din;
        if (is_byte) begin
            result = {8'h00, (addr_lsb ? din[15:8] : din[7:0])};
        end
        return result;
    endfunction

    function automatic logic [1:0] wtbt_encode(input logic we,
                                               input logic is_byte,
                                               input logic addr_lsb);
        logic [1:0] result;
        result = WTBT_NONE;
        if (we) begin
            if (!is_byte) begin
                result = WTBT_WORD;
            end else begin
                result = addr_lsb ? WTBT_HI : WTBT_LO;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bk_bus_initiator_if.sv
// bk_bus_initiator_if -- request/response port and BK bus signals of the
// bus initiator.
//   master : the initiator side (accepts requests, drives the bus)
//   slave  : the environment side (requester, arbiter and responders)
interface bk_bus_initiator_if;
    // request / response port
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    // BK bus
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_sync;
    logic        bus_we;
    logic [1:0]  bus_wtbt;
    logic        bus_stb;
    logic        bus_ack;

    modport master (
        input  req_valid, req_we, req_byte, req_addr, req_data,
        input  bus_gnt, bus_din, bus_ack,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output bus_req, bus_addr, bus_dout, bus_sync, bus_we, bus_wtbt, bus_stb
    );

    modport slave (
        output req_valid, req_we, req_byte, req_addr, req_data,
        output bus_gnt, bus_din, bus_ack,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  bus_req, bus_addr, bus_dout, bus_sync, bus_we, bus_wtbt, bus_stb
    );
endinterface

// File: rtl/bk_bus_initiator.sv
// bk_bus_initiator -- runs one single read or write on the BK bus per
// accepted request: arbitrate, one address cycle, strobe until ack or
// timeout, one release cycle, then a one-cycle response pulse.
//   clk_sys : system clock (rising edge)
//   reset   : asynchronous active-high reset
//   ifc     : request/response port and bus signals (master modport)
//   TIMEOUT : strobe cycles to wait for bus_ack (2..1023)
module bk_bus_initiator
    import bk_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    bk_bus_initiator_if.master    ifc
);

    localparam logic [9:0] CNT_LOAD = 10'(TIMEOUT - 1);

    bus_state_t  state_reg, state_next;

    logic        we_reg;
    logic        byte_reg;
    logic [15:0] addr_reg;
    logic [15:0] dout_reg;
    logic [9:0]  cnt_reg;
    logic        err_reg;
    logic [15:0] rd_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic [15:0] rsp_data_reg;

    logic        req_ready_c;
    logic        bus_req_c;
    logic        bus_sync_c;
    logic        bus_stb_c;

    // State register. Because the bus controls below decode state_reg,
    // reset drops sync/stb/req immediately, without a clock edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_ready_c = 1'b0;
        bus_req_c   = 1'b0;
        bus_sync_c  = 1'b0;
        bus_stb_c   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready_c = !reset;
                if (ifc.req_valid && !reset) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                bus_req_c = 1'b1;
                if (ifc.bus_gnt) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_req_c  = 1'b1;
                bus_sync_c = 1'b1;
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                bus_req_c  = 1'b1;
                bus_sync_c = 1'b1;
                bus_stb_c  = 1'b1;
                if (ifc.bus_ack || (cnt_reg == 10'd0)) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                bus_req_c  = 1'b1;
                bus_sync_c = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: request latch, timeout counter, read capture, response.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            we_reg        <= 1'b0;
            byte_reg      <= 1'b0;
            addr_reg      <= 16'h0000;
            dout_reg      <= 16'h0000;
            cnt_reg       <= 10'd0;
            err_reg       <= 1'b0;
            rd_reg        <= 16'h0000;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= 16'h0000;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ifc.req_valid) begin
                        we_reg   <= ifc.req_we;
                        byte_reg <= ifc.req_byte;
                        addr_reg <= ifc.req_addr;
                        dout_reg <= byte_replicate(ifc.req_data, ifc.req_byte);
                        err_reg  <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    cnt_reg <= CNT_LOAD;
                end
                ST_STROBE: begin
                    // Ack wins over an expiring counter in the same cycle.
                    if (ifc.bus_ack) begin
                        rd_reg <= byte_extract(ifc.bus_din, byte_reg, addr_reg[0]);
                    end else if (cnt_reg == 10'd0) begin
                        err_reg <= 1'b1;
                        rd_reg  <= 16'hFFFF;
                    end else begin
                        cnt_reg <= cnt_reg - 10'd1;
                    end
                end
                ST_RELEASE: begin
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= err_reg;
                    // Writes leave the last read data visible.
                    if (!we_reg) begin
                        rsp_data_reg <= rd_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ifc.req_ready = req_ready_c;
    assign ifc.rsp_valid = rsp_valid_reg;
    assign ifc.rsp_err   = rsp_err_reg;
    assign ifc.rsp_data  = rsp_data_reg;

    // Address-phase signals come straight from the request latch, so they
    // cannot move while sync is high; outside a cycle they idle at 0.
    assign ifc.bus_req  = bus_req_c;
    assign ifc.bus_sync = bus_sync_c;
    assign ifc.bus_stb  = bus_stb_c;
    assign ifc.bus_addr = bus_sync_c ? {addr_reg[15:1], 1'b0} : 16'h0000;
    assign ifc.bus_we   = bus_sync_c & we_reg;
    assign ifc.bus_wtbt = bus_sync_c ? wtbt_encode(we_reg, byte_reg, addr_reg[0]) : WTBT_NONE;
    assign ifc.bus_dout = bus_sync_c ? dout_reg : 16'h0000;

endmodule

// File: tb/tb_bk_bus_initiator.sv
module tb_bk_bus_initiator;

    localparam int TMO = 64;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    bk_bus_initiator_if bif();

    bk_bus_initiator #(.TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ifc     (bif.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- responder and arbiter models ----------------
    int          ack_delay = 1;
    bit          ack_en    = 1'b1;
    logic [15:0] din_val   = 16'h0000;
    int          gnt_delay = 0;
    bit          gnt_drop  = 1'b0;
    int          stb_seen  = 0;
    int          req_seen  = 0;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stb_seen <= 0;
            req_seen <= 0;
        end else begin
            stb_seen <= bif.bus_stb ? stb_seen + 1 : 0;
            req_seen <= bif.bus_req ? req_seen + 1 : 0;
        end
    end

    assign bif.bus_ack = bif.bus_stb && ack_en && (stb_seen == ack_delay - 1);
    assign bif.bus_din = bif.bus_ack ? din_val : ~din_val;
    assign bif.bus_gnt = bif.bus_req && (req_seen >= gnt_delay) && !(gnt_drop && bif.bus_stb);

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  wtbt;
        logic [15:0] dout;
        int          stb_len;
        int          arb_len;
    } bus_exp_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acc_cyc;
    } rsp_exp_t;

    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_q[$];
    logic [15:0] model_rsp_data = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    bit          in_cyc = 1'b0;
    logic [15:0] cap_addr, cap_dout;
    logic        cap_we;
    logic [1:0]  cap_wtbt;
    int          stb_n, sync_n, arb_n, arb_len_seen;
    bit          unstable, first_stb, last_stb, prev_gnt, gnt_ok;

    always @(negedge clk_sys) begin
        bus_exp_t e;
        if (reset) begin
            in_cyc   = 1'b0;
            arb_n    = 0;
            prev_gnt = 1'b0;
        end else begin
            if (bif.bus_sync) begin
                if (!in_cyc) begin
                    in_cyc       = 1'b1;
                    cap_addr     = bif.bus_addr;
                    cap_we       = bif.bus_we;
                    cap_wtbt     = bif.bus_wtbt;
                    cap_dout     = bif.bus_dout;
                    stb_n        = 0;
                    sync_n       = 0;
                    unstable     = 1'b0;
                    first_stb    = bif.bus_stb;
                    gnt_ok       = prev_gnt;
                    arb_len_seen = arb_n;
                    arb_n        = 0;
                end else if (bif.bus_addr !== cap_addr || bif.bus_we !== cap_we ||
                             bif.bus_wtbt !== cap_wtbt || bif.bus_dout !== cap_dout) begin
                    unstable = 1'b1;
                end
                sync_n++;
                if (bif.bus_stb) stb_n++;
                last_stb = bif.bus_stb;
            end else begin
                if (in_cyc) begin
                    in_cyc = 1'b0;
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_cycle", 32'd1, 32'd0);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_addr", cap_addr, e.addr);
                        chk("bus_we", cap_we, e.we);
                        chk("bus_wtbt", cap_wtbt, e.wtbt);
                        if (e.we) chk("bus_dout", cap_dout, e.dout);
                        chk("stb_cycles", stb_n, e.stb_len);
                        chk("sync_cycles", sync_n, e.stb_len + 2);
                        chk("addr_phase_stb", first_stb, 1'b0);
                        chk("release_phase_stb", last_stb, 1'b0);
                        chk("addr_stable", unstable, 1'b0);
                        chk("gnt_before_sync", gnt_ok, 1'b1);
                        chk("arb_req_cycles", arb_len_seen, e.arb_len);
                    end
                end
                if (bif.bus_req) arb_n++;
                prev_gnt = bif.bus_req && bif.bus_gnt;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk_sys) begin
        rsp_exp_t r;
        if (!reset) begin
            if (bif.rsp_err && !bif.rsp_valid) chk("rsp_err_unqualified", 32'd1, 32'd0);
            if (bif.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_data", bif.rsp_data, r.data);
                    chk("rsp_err", bif.rsp_err, r.err);
                    chk("rsp_latency", cyc - r.acc_cyc, r.lat);
                    $display("txn rsp data=0x%04h err=%0d latency=%0d", bif.rsp_data,
                             bif.rsp_err, cyc - r.acc_cyc);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic byt, input logic [15:0] addr,
                         input logic [15:0] data, input int adly, input bit aen,
                         input logic [15:0] din, input int gdly, input bit gdrop);
        int       n = 0;
        bus_exp_t be;
        rsp_exp_t re;
        @(negedge clk_sys);
        while (!bif.req_ready && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        if (!bif.req_ready) begin
            chk("req_ready_wait", 32'd0, 32'd1);
            return;
        end
        ack_delay = adly;
        ack_en    = aen;
        din_val   = din;
        gnt_delay = gdly;
        gnt_drop  = gdrop;
        bif.req_we    = we;
        bif.req_byte  = byt;
        bif.req_addr  = addr;
        bif.req_data  = data;
        bif.req_valid = 1'b1;

        // Expected outcome from the bus rules.
        be.addr    = {addr[15:1], 1'b0};
        be.we      = we;
        be.wtbt    = !we ? 2'b00 : (!byt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01));
        be.dout    = byt ? {data[7:0], data[7:0]} : data;
        be.stb_len = aen ? adly : TMO;
        be.arb_len = gdly + 1;
        if (!we) begin
            if (!aen)     model_rsp_data = 16'hFFFF;
            else if (byt) model_rsp_data = {8'h00, (addr[0] ? din[15:8] : din[7:0])};
            else          model_rsp_data = din;
        end
        re.data    = model_rsp_data;
        re.err     = !aen;
        re.lat     = be.stb_len + gdly + 4;
        re.acc_cyc = cyc;
        bus_q.push_back(be);
        rsp_q.push_back(re);
        $display("txn req we=%0d byte=%0d addr=0x%04h data=0x%04h ack_delay=%0d ack=%0d gnt_delay=%0d",
                 we, byt, addr, data, adly, aen, gdly);

        @(posedge clk_sys);
        #1;
        bif.req_valid = 1'b0;
        bif.req_data  = 16'($urandom);
        bif.req_addr  = 16'($urandom);
    endtask

    initial begin
        int n;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_byte  = 1'b0;
        bif.req_addr  = 16'h0000;
        bif.req_data  = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("reset_req_ready", bif.req_ready, 1'b0);
        chk("reset_bus_req", bif.bus_req, 1'b0);
        chk("reset_bus_sync", bif.bus_sync, 1'b0);
        chk("reset_bus_stb", bif.bus_stb, 1'b0);
        chk("reset_bus_addr", bif.bus_addr, 16'h0000);
        chk("reset_bus_we", bif.bus_we, 1'b0);
        chk("reset_bus_wtbt", bif.bus_wtbt, 2'b00);
        chk("reset_bus_dout", bif.bus_dout, 16'h0000);
        chk("reset_rsp_valid", bif.rsp_valid, 1'b0);
        chk("reset_rsp_err", bif.rsp_err, 1'b0);
        chk("reset_rsp_data", bif.rsp_data, 16'h0000);
        reset = 1'b0;

        // Directed cases
        issue(1'b1, 1'b0, 16'hFFB4, 16'h1234, 1, 1'b1, 16'h0F0F, 0, 1'b0); // word write 177664
        issue(1'b1, 1'b1, 16'h0201, 16'h00A5, 1, 1'b1, 16'h0000, 0, 1'b0); // byte write 001001
        issue(1'b0, 1'b1, 16'h0101, 16'h0000, 3, 1'b1, 16'hBEEF, 0, 1'b0); // byte read 000401
        issue(1'b0, 1'b0, 16'h3000, 16'h0000, 1, 1'b0, 16'h1111, 0, 1'b0); // timeout
        issue(1'b1, 1'b0, 16'h3002, 16'h7777, 1, 1'b0, 16'h2222, 0, 1'b0); // write timeout
        issue(1'b0, 1'b0, 16'h1000, 16'h0000, 2, 1'b1, 16'h5A5A, 10, 1'b0); // late grant
        issue(1'b0, 1'b1, 16'h1000, 16'h0000, 2, 1'b1, 16'hC3A7, 1, 1'b1);  // even byte, gnt drop

        // Reset during STROBE
        issue(1'b0, 1'b0, 16'h2000, 16'h0000, 1, 1'b0, 16'h0000, 0, 1'b0);
        n = 0;
        while (!bif.bus_stb && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("reach_strobe", bif.bus_stb, 1'b1);
        repeat (2) @(negedge clk_sys);
        #2;
        reset = 1'b1;
        bus_q.delete();
        rsp_q.delete();
        model_rsp_data = 16'h0000;
        #1;
        chk("async_reset_sync", bif.bus_sync, 1'b0);
        chk("async_reset_stb", bif.bus_stb, 1'b0);
        chk("async_reset_req", bif.bus_req, 1'b0);
        chk("async_reset_rsp_valid", bif.rsp_valid, 1'b0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        issue(1'b0, 1'b0, 16'h4444, 16'h0000, 2, 1'b1, 16'h9876, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  int'($urandom_range(1, 6)), ($urandom_range(0, 9) != 0),
                  16'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        end

        // Drain
        n = 0;
        while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("drain_bus_q", bus_q.size(), 0);
        chk("drain_rsp_q", rsp_q.size(), 0);
        repeat (5) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
